// File: rtl/fft_pkg.sv
// Shared sizes, timeout default and input-FSM state codes for the FFT stream controller.
package fft_pkg;

    localparam int FFT_WIDTH   = 16;
    localparam int FFT_N       = 16;
    localparam int FFT_LOG2N   = 4;
    localparam int FFT_TIMEOUT = 1023;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/fft_out_buffer.sv
// Result bank for one FFT frame: parallel load, then serialised out one bin per handshake.
module fft_out_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH*FFT_N-1:0] load_real,
    input  logic [WIDTH*FFT_N-1:0] load_imag,
    output logic                   empty_next,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_real,
    output logic [WIDTH-1:0]       out_imag,
    output logic [FFT_LOG2N-1:0]   out_index,
    output logic                   out_last
);

    logic [WIDTH-1:0]     bank_real [FFT_N];
    logic [WIDTH-1:0]     bank_imag [FFT_N];
    logic                 full;
    logic [FFT_LOG2N-1:0] rd_idx;

    assign out_valid  = full;
    assign out_index  = rd_idx;
    assign out_last   = &rd_idx;
    assign out_real   = bank_real[rd_idx];
    assign out_imag   = bank_imag[rd_idx];
    assign empty_next = full & out_ready & (&rd_idx);

    // Data bank carries no reset; it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < FFT_N; k++) begin
                bank_real[k] <= load_real[WIDTH*k +: WIDTH];
                bank_imag[k] <= load_imag[WIDTH*k +: WIDTH];
            end
        end
    end

    // A load on the same edge as the last-bin handshake wins, giving back-to-back frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            rd_idx <= '0;
        end else if (load) begin
            full   <= 1'b1;
            rd_idx <= '0;
        end else if (full && out_ready) begin
            rd_idx <= rd_idx + 1'b1;
            if (&rd_idx) full <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_stream_ctrl.sv
// Streaming front/back-end for a 16-point FFT core: frame fill, launch with timeout, result drain.
//   state  | meaning
//   FILL   | accepting samples into the input buffer
//   LAUNCH | one-cycle start pulse, timeout counter loaded
//   WAIT   | core running; done captures or defers, timeout aborts
//   HOLD   | result ready but output buffer still draining
module fft_stream_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH   = FFT_WIDTH,
    parameter int TIMEOUT = FFT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_real,
    input  logic [WIDTH-1:0]       in_imag,
    output logic                   fft_start,
    output logic [WIDTH*FFT_N-1:0] fft_in_real,
    output logic [WIDTH*FFT_N-1:0] fft_in_imag,
    input  logic [WIDTH*FFT_N-1:0] fft_out_real,
    input  logic [WIDTH*FFT_N-1:0] fft_out_imag,
    input  logic                   fft_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_real,
    output logic [WIDTH-1:0]       out_imag,
    output logic [FFT_LOG2N-1:0]   out_index,
    output logic                   out_last,
    output logic                   err_timeout,
    output logic [15:0]            frame_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [1:0]           state;
    logic [FFT_LOG2N-1:0] wr_idx;
    logic [WIDTH-1:0]     in_buf_real [FFT_N];
    logic [WIDTH-1:0]     in_buf_imag [FFT_N];
    logic [TO_W-1:0]      to_cnt;
    logic                 in_fire;
    logic                 load;
    logic                 empty_next;

    assign in_ready  = (state == ST_FILL);
    assign fft_start = (state == ST_LAUNCH);
    assign in_fire   = in_valid & in_ready;

    for (genvar k = 0; k < FFT_N; k++) begin : g_pack
        assign fft_in_real[WIDTH*k +: WIDTH] = in_buf_real[k];
        assign fft_in_imag[WIDTH*k +: WIDTH] = in_buf_imag[k];
    end

    // The buffer draining on this very edge counts as empty.
    always_comb begin
        load = 1'b0;
        if (state == ST_WAIT)      load = fft_done & (~out_valid | empty_next);
        else if (state == ST_HOLD) load = empty_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FFT_N; k++) begin
                in_buf_real[k] <= '0;
                in_buf_imag[k] <= '0;
            end
        end else if (in_fire) begin
            in_buf_real[wr_idx] <= in_real;
            in_buf_imag[wr_idx] <= in_imag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FILL;
            wr_idx      <= '0;
            to_cnt      <= '0;
            err_timeout <= 1'b0;
            frame_count <= '0;
        end else begin
            if (load) frame_count <= frame_count + 16'd1;
            case (state)
                ST_FILL: begin
                    if (in_fire) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (&wr_idx) state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    to_cnt <= TO_W'(TIMEOUT - 1);
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fft_done) begin
                        state <= load ? ST_FILL : ST_HOLD;
                    end else if (to_cnt == '0) begin
                        err_timeout <= 1'b1;
                        state       <= ST_FILL;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (load) state <= ST_FILL;
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    fft_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_real  (fft_out_real),
        .load_imag  (fft_out_imag),
        .empty_next (empty_next),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_index  (out_index),
        .out_last   (out_last)
    );

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Randomised bench for fft_stream_ctrl against a transaction-level queue model with a stub FFT core.
module tb_fft_stream_ctrl;

    localparam int W  = 16;
    localparam int NP = 16;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [W-1:0]    in_real, in_imag;
    logic            fft_start, fft_done;
    logic [W*NP-1:0] fft_in_real, fft_in_imag, fft_out_real, fft_out_imag;
    logic            out_valid, out_ready, out_last, err_timeout;
    logic [W-1:0]    out_real, out_imag;
    logic [3:0]      out_index;
    logic [15:0]     frame_count;

    always #5 clk = ~clk;

    fft_stream_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .fft_start(fft_start), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
        .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag), .fft_done(fft_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last),
        .err_timeout(err_timeout), .frame_count(frame_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    int valid_pct, ready_mode, stub_lat, stub_cd;
    bit stub_never, force_done, ramp;

    typedef struct packed { logic [15:0] re; logic [15:0] im; } bin_t;
    bin_t        q_cur[$];
    bin_t        q_held[$];
    logic [15:0] mbuf_re [NP];
    logic [15:0] mbuf_im [NP];
    logic [15:0] res_re  [NP];
    logic [15:0] res_im  [NP];
    int m_cnt, m_wait, m_drained;
    bit m_start, m_busy, m_holding, m_err;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic reset_model();
        m_cnt = 0; m_wait = 0; m_drained = 0;
        m_start = 0; m_busy = 0; m_holding = 0; m_err = 0;
        q_cur.delete(); q_held.delete();
        for (int k = 0; k < NP; k++) begin mbuf_re[k] = '0; mbuf_im[k] = '0; end
    endtask

    task automatic check_outputs();
        logic [255:0] e_re, e_im;
        int sz;
        for (int k = 0; k < NP; k++) begin
            e_re[16*k +: 16] = mbuf_re[k];
            e_im[16*k +: 16] = mbuf_im[k];
        end
        sz = q_cur.size();
        chk("in_ready",    256'(in_ready),    256'(!(m_start || m_busy)));
        chk("fft_start",   256'(fft_start),   256'(m_start));
        chk("out_valid",   256'(out_valid),   256'(sz != 0));
        chk("out_index",   256'(out_index),   256'((sz == 0) ? 0 : NP - sz));
        chk("out_last",    256'(out_last),    256'(sz == 1));
        chk("err_timeout", 256'(err_timeout), 256'(m_err));
        chk("frame_count", 256'(frame_count), 256'(16'(m_drained + ((sz != 0) ? 1 : 0))));
        chk("fft_in_real", fft_in_real, e_re);
        chk("fft_in_imag", fft_in_imag, e_im);
        if (sz != 0) begin
            chk("out_real", 256'(out_real), 256'(q_cur[0].re));
            chk("out_imag", 256'(out_imag), 256'(q_cur[0].im));
        end
        if (ramp && m_start) begin
            chk("ramp_re1",  256'(fft_in_real[31:16]),   256'(16'd100));
            chk("ramp_im15", 256'(fft_in_imag[255:240]), 256'(16'hFFF1));
        end
    endtask

    // One cycle: check state after the last edge, drive inputs, advance the model over the next edge.
    task automatic step();
        bit done_now = 0;
        bit hs_in, hs_out, next_start;
        bin_t res[$];
        @(negedge clk);
        check_outputs();
        in_valid = ($urandom_range(99) < valid_pct);
        if (ramp) begin
            in_real = 16'(m_cnt * 100);
            in_imag = 16'(-m_cnt);
        end else begin
            in_real = 16'($urandom);
            in_imag = 16'($urandom);
        end
        case (ready_mode)
            0: out_ready = ($urandom_range(99) < 60);
            1: out_ready = ~out_ready;
            2: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
        fft_done = 1'b0;
        if (stub_cd > 0) begin
            stub_cd--;
            if (stub_cd == 0) done_now = 1;
        end
        if (fft_start === 1'b1 && !stub_never)
            stub_cd = (stub_lat == 0) ? $urandom_range(1, 12) : stub_lat;
        if (done_now || force_done) begin
            for (int k = 0; k < NP; k++) begin
                res_re[k] = 16'($urandom);
                res_im[k] = 16'($urandom);
                fft_out_real[16*k +: 16] = res_re[k];
                fft_out_imag[16*k +: 16] = res_im[k];
            end
            fft_done = 1'b1;
        end
        force_done = 0;

        hs_in  = in_valid && !(m_start || m_busy);
        hs_out = out_ready && (q_cur.size() != 0);
        next_start = 0;
        if (hs_in) begin
            mbuf_re[m_cnt] = in_real;
            mbuf_im[m_cnt] = in_imag;
            m_cnt++;
            if (m_cnt == NP) begin m_cnt = 0; next_start = 1; end
        end
        if (m_busy && !m_holding) begin
            if (fft_done) begin
                for (int k = 0; k < NP; k++) res.push_back('{re: res_re[k], im: res_im[k]});
                q_held = res;
                m_holding = 1;
            end else begin
                m_wait++;
                if (m_wait == TO) begin m_err = 1; m_busy = 0; end
            end
        end
        if (hs_out) begin
            void'(q_cur.pop_front());
            if (q_cur.size() == 0) m_drained++;
        end
        if (m_holding && q_cur.size() == 0) begin
            q_cur = q_held;
            q_held.delete();
            m_holding = 0;
            m_busy = 0;
        end
        if (m_start) begin m_busy = 1; m_wait = 0; end
        m_start = next_start;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
        out_ready = 1'b0; fft_done = 1'b0; fft_out_real = '0; fft_out_imag = '0;
        valid_pct = 0; ready_mode = 3; stub_lat = 3; stub_cd = 0;
        stub_never = 0; force_done = 0; ramp = 0;
        reset_model();
        #3 check_outputs();
        @(negedge clk) rst_n = 1'b1;

        // ramp frames, continuous valid, fixed latency
        ramp = 1; valid_pct = 100; ready_mode = 3; stub_lat = 3;
        repeat (40) step();
        valid_pct = 0;
        repeat (30) step();
        ramp = 0;

        // random traffic and random core latency
        valid_pct = 70; ready_mode = 0; stub_lat = 0;
        repeat (300) step();

        // done while idle must not capture
        valid_pct = 0; ready_mode = 3;
        repeat (40) step();
        force_done = 1;
        repeat (4) step();

        // alternating backpressure
        valid_pct = 100; ready_mode = 1; stub_lat = 4;
        repeat (80) step();

        // second result completes while the first is still stalled
        ready_mode = 2; stub_lat = 3;
        repeat (60) step();
        chk("hold_in_ready", 256'(in_ready), 256'(1'b0));
        chk("hold_out_valid", 256'(out_valid), 256'(1'b1));
        ready_mode = 3; valid_pct = 0;
        repeat (60) step();

        // core never completes
        stub_never = 1; valid_pct = 100; ready_mode = 3;
        repeat (50) step();
        chk("timeout_sticky", 256'(err_timeout), 256'(1'b1));
        stub_never = 0;
        valid_pct = 0;
        repeat (30) step();

        // async reset in the middle of a drain
        valid_pct = 100; ready_mode = 2; stub_lat = 2;
        for (int i = 0; i < 200 && q_cur.size() != NP; i++) step();
        valid_pct = 0; ready_mode = 3;
        repeat (6) step();
        @(posedge clk);
        #1 chk("pre_reset_index", 256'(out_index), 256'(4'd6));
        #1 rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; fft_done = 1'b0; stub_cd = 0;
        reset_model();
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;

        // normal traffic after reset, then drain
        valid_pct = 80; ready_mode = 0; stub_lat = 0;
        repeat (200) step();
        valid_pct = 0; ready_mode = 3;
        repeat (60) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
